mm_sequencer: RTL and testbench
===============================

MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 SHALL have parameter DIM, default 16: weight rows loaded per operation, one per systolic array row.
REQ-002 SHALL have parameter PIPE_LAT, default 31: cycles from MMU data entry to valid MMU result.
REQ-003 SHALL have ports:
  clk  in  1  single clock; all state on rising edge.
  reset  in  1  asynchronous, active-high.
  start  in  1  one-cycle operation request.
  abort  in  1  synchronous cancel of the running operation.
  cfg_w_base  in  8  WB start address.
  cfg_d_base  in  8  UB start address.
  cfg_a_base  in  8  ACC start address.
  cfg_rows  in  9  data rows to stream; legal range 1..256.
  cfg_acc  in  1  1 = accumulate into ACC; 0 = overwrite.
  busy  out  1  operation in progress.
  done  out  1  one-cycle completion pulse.
  err  out  1  one-cycle pulse on a rejected start.
  wb_ren  out  1  weight buffer read enable.
  wb_raddr  out  8  weight buffer read address.
  wfifo_en  out  1  weight FIFO shift enable.
  mmu_wen  out  1  MMU weight load enable.
  ub_ren  out  1  unified buffer read enable.
  ub_raddr  out  8  unified buffer read address.
  dfifo_en  out  1  data FIFO shift enable.
  mm_en  out  1  MMU compute enable.
  acc_wea  out  1  accumulator write strobe.
  acc_en  out  1  accumulate mode, qualified by acc_wea.
  acc_waddr  out  8  accumulator write address.

Function
REQ-004 SHALL implement the states IDLE, WFETCH, STREAM, DRAIN and DONE.
REQ-005 In IDLE with start=1, SHALL accept the request only when 1<=cfg_rows<=256, latch all cfg_* values and enter WFETCH on the next cycle.
REQ-006 In IDLE with start=1 and cfg_rows of 0 or 257..511, SHALL stay in IDLE and pulse err for 1 cycle.
REQ-007 SHALL ignore start while busy=1, with no err pulse and no change to the latched configuration.
REQ-008 WFETCH SHALL last DIM+1 cycles, with the cycle index w counting from 0.
  - wb_ren=1 for w=0..DIM-1.
  - wb_raddr=(w_base+w) mod 256.
  - wfifo_en=1 and mmu_wen=1 for w=1..DIM (1-cycle BRAM read latency).
  - Afterwards the FSM SHALL enter STREAM.
REQ-009 STREAM and DRAIN SHALL share a cycle counter c, starting at 0 on STREAM entry.
  - ub_ren=1 for c=0..rows-1.
  - ub_raddr=(d_base+c) mod 256.
  - dfifo_en=1 and mm_en=1 for c=1..rows+PIPE_LAT.
  - acc_wea=1 for c=PIPE_LAT+1..rows+PIPE_LAT.
  - acc_waddr=(a_base+c-PIPE_LAT-1) mod 256.
  - acc_en=latched cfg_acc while acc_wea=1, and 0 otherwise.
REQ-010 SHALL move from STREAM to DRAIN after c=rows-1, and from DRAIN to DONE after c=rows+PIPE_LAT.
REQ-011 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-012 busy SHALL be 1 in WFETCH, STREAM, DRAIN and DONE, and 0 in IDLE.
REQ-013 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse; all strobes SHALL be 0 from that edge on.
REQ-014 abort SHALL have priority over start in the same cycle; abort in IDLE SHALL have no effect.
REQ-015 Address counters SHALL wrap modulo 256 without error (for example, base 0xFE with 4 rows gives FE, FF, 00, 01).
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-017 reset=1 SHALL asynchronously force IDLE, including in the middle of an operation.
REQ-018 reset=1 SHALL asynchronously clear all counters, all latched configuration and every output to 0.
REQ-019 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-020 With macro MM_SEQ_PERF_CNT_EN defined, SHALL add output perf_cycles, 32 bits:
  - cleared to 0 on an accepted start;
  - incremented on every cycle with busy=1;
  - saturating at 0xFFFFFFFF;
  - held while in IDLE;
  - 0 on reset.
REQ-021 Without MM_SEQ_PERF_CNT_EN, port perf_cycles and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 Start at cycle 0 with DIM=16, PIPE_LAT=31, rows=4, bases W=0x10, D=0x20, A=0x30, cfg_acc=1 SHALL produce:
  - wb_raddr 0x10..0x1F over cycles 1..16;
  - mmu_wen over cycles 2..17;
  - ub_raddr 0x20..0x23 over cycles 18..21;
  - acc_wea with acc_en=1 and addresses 0x30..0x33 over cycles 50..53;
  - done at cycle 54;
  - perf_cycles=54, when MM_SEQ_PERF_CNT_EN is defined.
REQ-023 cfg_rows=0 and cfg_rows=300 SHALL each produce an err pulse with busy staying 0 and no strobes.
REQ-024 rows=256 with D=0xFE SHALL produce ub_raddr wrapping FE, FF, 00 .. FD, and exactly 256 acc_wea cycles.
REQ-025 A second start while busy SHALL be ignored: exactly one done pulse and no err.
REQ-026 abort during STREAM SHALL give busy=0 and all strobes 0 on the next cycle, with no done pulse; a new start SHALL then succeed.
REQ-027 reset asserted during DRAIN SHALL clear all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mm_sequencer.sv
// Matrix-multiply sequencer: weight fetch, data streaming and pipeline drain for a DIM-row systolic MMU.
// Optional MM_SEQ_PERF_CNT_EN adds a saturating 32-bit busy-cycle counter on perf_cycles.
module mm_sequencer #(
    parameter int DIM      = 16,
    parameter int PIPE_LAT = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_w_base,
    input  logic [7:0] cfg_d_base,
    input  logic [7:0] cfg_a_base,
    input  logic [8:0] cfg_rows,
    input  logic       cfg_acc,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       wb_ren,
    output logic [7:0] wb_raddr,
    output logic       wfifo_en,
    output logic       mmu_wen,
    output logic       ub_ren,
    output logic [7:0] ub_raddr,
    output logic       dfifo_en,
    output logic       mm_en,
    output logic       acc_wea,
    output logic       acc_en,
    output logic [7:0] acc_waddr
`ifdef MM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WFETCH = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [15:0] DIM_C  = 16'(DIM);
    localparam logic [15:0] PL_C   = 16'(PIPE_LAT);
    localparam logic [15:0] ACC_LO = 16'(PIPE_LAT + 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  w_base_q, d_base_q, a_base_q;
    logic [7:0]  w_base_d, d_base_d, a_base_d;
    logic [8:0]  rows_q, rows_d;
    logic        acc_q, acc_d;

    logic        rows_ok, accept, reject;
    logic [15:0] rows_ext, last_c;

    logic        nxt_busy, nxt_done, nxt_err;
    logic        nxt_wb_ren, nxt_wfifo_en, nxt_mmu_wen;
    logic        nxt_ub_ren, nxt_dfifo_en, nxt_mm_en;
    logic        nxt_acc_wea, nxt_acc_en;
    logic [7:0]  nxt_wb_raddr, nxt_ub_raddr, nxt_acc_waddr;

    // Request qualification and configuration capture on the accepting edge.
    always_comb begin
        rows_ok  = (cfg_rows != 9'd0) && (cfg_rows <= 9'd256);
        accept   = (state_q == S_IDLE) && start && rows_ok;
        reject   = (state_q == S_IDLE) && start && !rows_ok;
        w_base_d = accept ? cfg_w_base : w_base_q;
        d_base_d = accept ? cfg_d_base : d_base_q;
        a_base_d = accept ? cfg_a_base : a_base_q;
        rows_d   = accept ? cfg_rows   : rows_q;
        acc_d    = accept ? cfg_acc    : acc_q;
        rows_ext = {7'd0, rows_d};
        last_c   = rows_ext + PL_C;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WFETCH;
                    cnt_d   = 16'd0;
                end
            end
            S_WFETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == DIM_C) begin
                    state_d = S_STREAM;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == rows_ext - 16'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == last_c) begin
                    state_d = S_DONE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state/count so the registered copies line up with the state.
    always_comb begin
        nxt_busy      = (state_d != S_IDLE);
        nxt_done      = (state_d == S_DONE);
        nxt_err       = reject;
        nxt_wb_ren    = 1'b0;
        nxt_wb_raddr  = 8'd0;
        nxt_wfifo_en  = 1'b0;
        nxt_mmu_wen   = 1'b0;
        nxt_ub_ren    = 1'b0;
        nxt_ub_raddr  = 8'd0;
        nxt_dfifo_en  = 1'b0;
        nxt_mm_en     = 1'b0;
        nxt_acc_wea   = 1'b0;
        nxt_acc_en    = 1'b0;
        nxt_acc_waddr = 8'd0;
        if (state_d == S_WFETCH) begin
            nxt_wb_ren   = (cnt_d < DIM_C);
            nxt_wb_raddr = nxt_wb_ren ? (w_base_d + cnt_d[7:0]) : 8'd0;
            nxt_wfifo_en = (cnt_d != 16'd0);
            nxt_mmu_wen  = (cnt_d != 16'd0);
        end
        if ((state_d == S_STREAM) || (state_d == S_DRAIN)) begin
            nxt_ub_ren    = (cnt_d < rows_ext);
            nxt_ub_raddr  = nxt_ub_ren ? (d_base_d + cnt_d[7:0]) : 8'd0;
            nxt_dfifo_en  = (cnt_d != 16'd0) && (cnt_d <= last_c);
            nxt_mm_en     = nxt_dfifo_en;
            nxt_acc_wea   = (cnt_d >= ACC_LO) && (cnt_d <= last_c);
            nxt_acc_en    = nxt_acc_wea && acc_d;
            nxt_acc_waddr = nxt_acc_wea ? (a_base_d + cnt_d[7:0] - ACC_LO[7:0]) : 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            w_base_q <= 8'd0;
            d_base_q <= 8'd0;
            a_base_q <= 8'd0;
            rows_q   <= 9'd0;
            acc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_base_q <= w_base_d;
            d_base_q <= d_base_d;
            a_base_q <= a_base_d;
            rows_q   <= rows_d;
            acc_q    <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wb_ren    <= 1'b0;
            wb_raddr  <= 8'd0;
            wfifo_en  <= 1'b0;
            mmu_wen   <= 1'b0;
            ub_ren    <= 1'b0;
            ub_raddr  <= 8'd0;
            dfifo_en  <= 1'b0;
            mm_en     <= 1'b0;
            acc_wea   <= 1'b0;
            acc_en    <= 1'b0;
            acc_waddr <= 8'd0;
        end else begin
            busy      <= nxt_busy;
            done      <= nxt_done;
            err       <= nxt_err;
            wb_ren    <= nxt_wb_ren;
            wb_raddr  <= nxt_wb_raddr;
            wfifo_en  <= nxt_wfifo_en;
            mmu_wen   <= nxt_mmu_wen;
            ub_ren    <= nxt_ub_ren;
            ub_raddr  <= nxt_ub_raddr;
            dfifo_en  <= nxt_dfifo_en;
            mm_en     <= nxt_mm_en;
            acc_wea   <= nxt_acc_wea;
            acc_en    <= nxt_acc_en;
            acc_waddr <= nxt_acc_waddr;
        end
    end

`ifdef MM_SEQ_PERF_CNT_EN
    // Counts every busy cycle of the current operation and holds the total while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= 32'd0;
        end else if (accept) begin
            perf_cycles <= 32'd0;
        end else if ((state_q != S_IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed self-checking bench for mm_sequencer with DIM=16, PIPE_LAT=31.
module tb_mm_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] cfg_w_base, cfg_d_base, cfg_a_base;
    logic [8:0] cfg_rows;
    logic       cfg_acc;
    logic       busy, done, err;
    logic       wb_ren, wfifo_en, mmu_wen, ub_ren, dfifo_en, mm_en, acc_wea, acc_en;
    logic [7:0] wb_raddr, ub_raddr, acc_waddr;
`ifdef MM_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    int tests = 0;
    int fails = 0;

    // {busy,done,err,wb_ren,wfifo_en,mmu_wen,ub_ren,dfifo_en,mm_en,acc_wea,acc_en}
    logic [10:0] strobes;
    assign strobes = {busy, done, err, wb_ren, wfifo_en, mmu_wen, ub_ren, dfifo_en, mm_en, acc_wea, acc_en};

    mm_sequencer #(.DIM(16), .PIPE_LAT(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_w_base (cfg_w_base),
        .cfg_d_base (cfg_d_base),
        .cfg_a_base (cfg_a_base),
        .cfg_rows   (cfg_rows),
        .cfg_acc    (cfg_acc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wb_ren     (wb_ren),
        .wb_raddr   (wb_raddr),
        .wfifo_en   (wfifo_en),
        .mmu_wen    (mmu_wen),
        .ub_ren     (ub_ren),
        .ub_raddr   (ub_raddr),
        .dfifo_en   (dfifo_en),
        .mm_en      (mm_en),
        .acc_wea    (acc_wea),
        .acc_en     (acc_en),
        .acc_waddr  (acc_waddr)
`ifdef MM_SEQ_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns at cycle 1 (one edge after the start was sampled).
    task automatic launch(input logic [8:0] rows, input logic [7:0] wb, input logic [7:0] db,
                          input logic [7:0] ab, input logic acc);
        cfg_rows   = rows;
        cfg_w_base = wb;
        cfg_d_base = db;
        cfg_a_base = ab;
        cfg_acc    = acc;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_rows = 9'd0; cfg_w_base = 8'd0; cfg_d_base = 8'd0; cfg_a_base = 8'd0; cfg_acc = 1'b0;
        #2;
        tests++;
        if ({strobes, wb_raddr, ub_raddr, acc_waddr} !== 35'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h, want 0", {strobes, wb_raddr, ub_raddr, acc_waddr});
        end
        tick();
        tick();
        tests++;
        if (strobes !== 11'd0) begin
            fails++;
            $display("[TB] FAIL reset_held: got %b, want 0", strobes);
        end
`ifdef MM_SEQ_PERF_CNT_EN
        tests++;
        if (perf_cycles !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_perf: got %0d, want 0", perf_cycles);
        end
`endif
    endtask

    // Release reset and start in the same cycle: the first edge after release must accept.
    task automatic test_basic;
        logic [10:0] exp;
        reset = 1'b0;
        launch(9'd4, 8'h10, 8'h20, 8'h30, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            exp     = 11'd0;
            exp[10] = (k <= 54);
            exp[9]  = (k == 54);
            exp[7]  = (k >= 1 && k <= 16);
            exp[6]  = (k >= 2 && k <= 17);
            exp[5]  = (k >= 2 && k <= 17);
            exp[4]  = (k >= 18 && k <= 21);
            exp[3]  = (k >= 19 && k <= 53);
            exp[2]  = (k >= 19 && k <= 53);
            exp[1]  = (k >= 50 && k <= 53);
            exp[0]  = (k >= 50 && k <= 53);
            tests++;
            if (strobes !== exp) begin
                fails++;
                $display("[TB] FAIL basic_strobes cycle %0d: got %b, want %b", k, strobes, exp);
            end
            if (k >= 1 && k <= 16) begin
                tests++;
                if (wb_raddr !== 8'(32'h10 + k - 1)) begin
                    fails++;
                    $display("[TB] FAIL basic_wb_raddr cycle %0d: got %h, want %h", k, wb_raddr, 8'(32'h10 + k - 1));
                end
            end
            if (k >= 18 && k <= 21) begin
                tests++;
                if (ub_raddr !== 8'(32'h20 + k - 18)) begin
                    fails++;
                    $display("[TB] FAIL basic_ub_raddr cycle %0d: got %h, want %h", k, ub_raddr, 8'(32'h20 + k - 18));
                end
            end
            if (k >= 50 && k <= 53) begin
                tests++;
                if (acc_waddr !== 8'(32'h30 + k - 50)) begin
                    fails++;
                    $display("[TB] FAIL basic_acc_waddr cycle %0d: got %h, want %h", k, acc_waddr, 8'(32'h30 + k - 50));
                end
            end
            tick();
        end
`ifdef MM_SEQ_PERF_CNT_EN
        tests++;
        if (perf_cycles !== 32'd54) begin
            fails++;
            $display("[TB] FAIL basic_perf: got %0d, want 54", perf_cycles);
        end
`endif
    endtask

    task automatic test_bad_rows;
        logic [8:0] bad [3];
        bad[0] = 9'd0;
        bad[1] = 9'd300;
        bad[2] = 9'd257;
        for (int i = 0; i < 3; i++) begin
            launch(bad[i], 8'h01, 8'h02, 8'h03, 1'b1);
            tests++;
            if (strobes !== 11'b001_0000_0000) begin
                fails++;
                $display("[TB] FAIL bad_rows_err rows=%0d: got %b, want 00100000000", bad[i], strobes);
            end
            tick();
            tests++;
            if (strobes !== 11'd0) begin
                fails++;
                $display("[TB] FAIL bad_rows_idle rows=%0d: got %b, want 0", bad[i], strobes);
            end
        end
    endtask

    task automatic test_wrap;
        int ub_n, acc_n, done_k;
        ub_n = 0; acc_n = 0; done_k = -1;
        launch(9'd256, 8'h00, 8'hFE, 8'h00, 1'b0);
        for (int k = 1; k <= 400; k++) begin
            if (ub_ren) begin
                tests++;
                if (ub_raddr !== 8'(32'hFE + ub_n)) begin
                    fails++;
                    $display("[TB] FAIL wrap_ub_raddr index %0d: got %h, want %h", ub_n, ub_raddr, 8'(32'hFE + ub_n));
                end
                ub_n++;
            end
            if (acc_wea) begin
                tests++;
                if ({acc_en, acc_waddr} !== {1'b0, 8'(acc_n)}) begin
                    fails++;
                    $display("[TB] FAIL wrap_acc index %0d: got en=%b addr=%h, want en=0 addr=%h", acc_n, acc_en, acc_waddr, 8'(acc_n));
                end
                acc_n++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            tick();
        end
        tick();
        tests++;
        if (ub_n != 256 || acc_n != 256) begin
            fails++;
            $display("[TB] FAIL wrap_counts: got ub=%0d acc=%0d, want 256 and 256", ub_n, acc_n);
        end
        tests++;
        if (done_k != 306) begin
            fails++;
            $display("[TB] FAIL wrap_done_cycle: got %0d, want 306", done_k);
        end
    endtask

    task automatic test_back_to_back;
        int done_n, err_n, ub_n, done_k;
        done_n = 0; err_n = 0; ub_n = 0; done_k = -1;
        launch(9'd4, 8'h10, 8'h20, 8'h30, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            if (done) begin done_n++; done_k = k; end
            if (err) err_n++;
            if (ub_ren) begin
                tests++;
                if (ub_raddr !== 8'(32'h20 + ub_n)) begin
                    fails++;
                    $display("[TB] FAIL b2b_ub_raddr index %0d: got %h, want %h", ub_n, ub_raddr, 8'(32'h20 + ub_n));
                end
                ub_n++;
            end
            if (k == 5) begin
                start = 1'b1;
                cfg_rows = 9'd1;
                cfg_d_base = 8'h80;
            end
            if (k == 6) start = 1'b0;
            tick();
        end
        tests++;
        if (done_n != 1 || done_k != 54 || err_n != 0 || ub_n != 4) begin
            fails++;
            $display("[TB] FAIL b2b_summary: got done=%0d at %0d err=%0d ub=%0d, want 1 at 54, 0, 4",
                     done_n, done_k, err_n, ub_n);
        end
    endtask

    task automatic test_abort;
        int done_n, acc_n, done_k;
        logic [7:0] first_acc;
        done_n = 0; acc_n = 0; done_k = -1; first_acc = 8'hxx;
        launch(9'd4, 8'h10, 8'h20, 8'h30, 1'b1);
        for (int k = 1; k < 19; k++) tick();
        tests++;
        if ({busy, ub_ren, ub_raddr} !== {1'b1, 1'b1, 8'h21}) begin
            fails++;
            $display("[TB] FAIL abort_pre: got busy=%b ub_ren=%b addr=%h, want 1 1 21", busy, ub_ren, ub_raddr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (strobes !== 11'd0) begin
            fails++;
            $display("[TB] FAIL abort_next: got %b, want 0", strobes);
        end
        for (int k = 0; k < 60; k++) begin
            if (done || busy) done_n++;
            tick();
        end
        tests++;
        if (done_n != 0) begin
            fails++;
            $display("[TB] FAIL abort_quiet: got %0d busy/done cycles, want 0", done_n);
        end
        launch(9'd2, 8'h40, 8'h50, 8'h60, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            if (acc_wea) begin
                if (acc_n == 0) first_acc = acc_waddr;
                if (acc_en) acc_n += 100;
                acc_n++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            tick();
        end
        tick();
        tests++;
        if (done_k != 52 || acc_n != 2 || first_acc !== 8'h60) begin
            fails++;
            $display("[TB] FAIL abort_restart: got done at %0d acc=%0d first=%h, want 52, 2, 60",
                     done_k, acc_n, first_acc);
        end
    endtask

    task automatic test_reset_drain;
        launch(9'd4, 8'h10, 8'h20, 8'h30, 1'b1);
        for (int k = 1; k < 30; k++) tick();
        tests++;
        if ({busy, mm_en, ub_ren} !== 3'b110) begin
            fails++;
            $display("[TB] FAIL drain_pre: got busy=%b mm_en=%b ub_ren=%b, want 1 1 0", busy, mm_en, ub_ren);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({strobes, wb_raddr, ub_raddr, acc_waddr} !== 35'd0) begin
            fails++;
            $display("[TB] FAIL drain_reset_async: got %h, want 0", {strobes, wb_raddr, ub_raddr, acc_waddr});
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (strobes !== 11'd0) begin
            fails++;
            $display("[TB] FAIL drain_reset_idle: got %b, want 0", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_rows();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
